// File: rtl/universal_shift_reg.sv
// universal_shift_reg: N-bit register with hold/load/shift/rotate/ASR/clear modes,
// selectable active clock edge, and registered zero/carry flags.
module universal_shift_reg #(
    parameter int          WIDTH     = 8,
    parameter bit          CLK_NEG   = 1'b1,
    parameter logic [31:0] RESET_VAL = 32'd0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] D,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] Q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             zero,
    output logic             carry
);
    localparam logic [WIDTH-1:0] RST_Q    = RESET_VAL[WIDTH-1:0];
    localparam logic [2:0]       M_HOLD   = 3'b000;
    localparam logic [2:0]       M_LOAD   = 3'b001;
    localparam logic [2:0]       M_SHL    = 3'b010;
    localparam logic [2:0]       M_SHR    = 3'b011;
    localparam logic [2:0]       M_ROL    = 3'b100;
    localparam logic [2:0]       M_ROR    = 3'b101;
    localparam logic [2:0]       M_ASR    = 3'b110;
    localparam logic [2:0]       M_CLR    = 3'b111;

    logic [WIDTH-1:0] q_q, q_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;

    always_comb begin
        q_d     = q_q;
        carry_d = carry_q;
        if (en) begin
            case (mode)
                M_HOLD: ;
                M_LOAD: begin q_d = D;                             carry_d = 1'b0;           end
                M_SHL:  begin q_d = {q_q[WIDTH-2:0], sin_l};       carry_d = q_q[WIDTH-1];   end
                M_SHR:  begin q_d = {sin_r, q_q[WIDTH-1:1]};       carry_d = q_q[0];         end
                M_ROL:  begin q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]}; carry_d = q_q[WIDTH-1];  end
                M_ROR:  begin q_d = {q_q[0], q_q[WIDTH-1:1]};      carry_d = q_q[0];         end
                M_ASR:  begin q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]}; carry_d = q_q[0];        end
                M_CLR:  begin q_d = '0;                            carry_d = 1'b0;           end
                default: ;
            endcase
        end
        // Flag tracks the next Q so it lands on the same edge as the data.
        zero_d = ~|q_d;
    end

    generate
        if (CLK_NEG) begin : g_neg
            always_ff @(negedge clk or posedge reset) begin
                if (reset) begin
                    q_q     <= RST_Q;
                    carry_q <= 1'b0;
                    zero_q  <= (RST_Q == '0);
                end else begin
                    q_q     <= q_d;
                    carry_q <= carry_d;
                    zero_q  <= zero_d;
                end
            end
        end else begin : g_pos
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    q_q     <= RST_Q;
                    carry_q <= 1'b0;
                    zero_q  <= (RST_Q == '0);
                end else begin
                    q_q     <= q_d;
                    carry_q <= carry_d;
                    zero_q  <= zero_d;
                end
            end
        end
    endgenerate

    assign Q      = q_q;
    assign sout_l = q_q[WIDTH-1];
    assign sout_r = q_q[0];
    assign zero   = zero_q;
    assign carry  = carry_q;
endmodule
